// File: rtl/dice_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : dice_score_keeper
//  Brief    : Two-player score keeper fed by the dice roll button and value.
//             Handles turns, the bonus turn on a six, and winner detection.
//  Revision : 1.0 - initial release
// ============================================================================
module dice_score_keeper #(
    parameter int TARGET   = 30,
    parameter int SCORE_W  = 6,
    parameter int MIN_HOLD = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    output logic               player,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic [2:0]         last,
    output logic               roll_valid,
    output logic               bad_throw,
    output logic               game_over,
    output logic               winner
);

    localparam int HOLD_W = (MIN_HOLD < 2) ? 1 : $clog2(MIN_HOLD + 1);

    localparam logic [HOLD_W-1:0]  c_MIN_HOLD   = HOLD_W'(MIN_HOLD);
    localparam logic [SCORE_W:0]   c_TARGET_EXT = (SCORE_W + 1)'(TARGET);
    localparam logic [SCORE_W-1:0] c_TARGET     = SCORE_W'(TARGET);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic               r_btn_q;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_player;
    logic [SCORE_W-1:0] r_score0;
    logic [SCORE_W-1:0] r_score1;
    logic [2:0]         r_last;
    logic               r_roll_valid;
    logic               r_bad_throw;
    logic               r_game_over;
    logic               r_winner;

    logic [SCORE_W-1:0] w_cur_score;
    logic [SCORE_W:0]   w_sum;
    logic               w_release;
    logic               w_qualified;
    logic               w_throw_ok;
    logic               w_win;
    logic [SCORE_W-1:0] w_new_score;

    // Sum is one bit wider than a score so the target compare cannot wrap.
    assign w_cur_score = r_player ? r_score1 : r_score0;
    assign w_sum       = {1'b0, w_cur_score} + {{(SCORE_W - 2){1'b0}}, throw};
    assign w_release   = (r_state == S_HELD) && r_btn_q && !button;
    assign w_qualified = w_release && (r_hold_cnt >= c_MIN_HOLD);
    assign w_throw_ok  = (throw != 3'd0) && (throw != 3'd7);
    assign w_win       = (w_sum >= c_TARGET_EXT);
    assign w_new_score = w_win ? c_TARGET : w_sum[SCORE_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_btn_q      <= 1'b0;
            r_hold_cnt   <= '0;
            r_player     <= 1'b0;
            r_score0     <= '0;
            r_score1     <= '0;
            r_last       <= 3'd0;
            r_roll_valid <= 1'b0;
            r_bad_throw  <= 1'b0;
            r_game_over  <= 1'b0;
            r_winner     <= 1'b0;
        end else begin
            r_roll_valid <= 1'b0;
            r_bad_throw  <= 1'b0;
            r_btn_q      <= button;

            if (!button) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt < c_MIN_HOLD) begin
                r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (button) begin
                        r_state <= S_HELD;
                    end
                end
                S_HELD: begin
                    if (w_release) begin
                        r_state <= S_IDLE;
                    end
                    if (w_qualified && !w_throw_ok) begin
                        r_bad_throw <= 1'b1;
                    end else if (w_qualified) begin
                        r_roll_valid <= 1'b1;
                        r_last       <= throw;
                        if (r_player) begin
                            r_score1 <= w_new_score;
                        end else begin
                            r_score0 <= w_new_score;
                        end
                        if (w_win) begin
                            r_game_over <= 1'b1;
                            r_winner    <= r_player;
                            r_state     <= S_DONE;
                        end else if (throw != 3'd6) begin
                            r_player <= ~r_player;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign player     = r_player;
    assign score0     = r_score0;
    assign score1     = r_score1;
    assign last       = r_last;
    assign roll_valid = r_roll_valid;
    assign bad_throw  = r_bad_throw;
    assign game_over  = r_game_over;
    assign winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_dice_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dice_score_keeper
//  Brief    : Scoreboard bench for dice_score_keeper with a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dice_score_keeper;

    localparam int TARGET   = 30;
    localparam int SW       = 6;
    localparam int MIN_HOLD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          button;
    logic [2:0]    throw;
    logic          player;
    logic [SW-1:0] score0;
    logic [SW-1:0] score1;
    logic [2:0]    last;
    logic          roll_valid;
    logic          bad_throw;
    logic          game_over;
    logic          winner;

    dice_score_keeper #(
        .TARGET   (TARGET),
        .SCORE_W  (SW),
        .MIN_HOLD (MIN_HOLD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .button     (button),
        .throw      (throw),
        .player     (player),
        .score0     (score0),
        .score1     (score1),
        .last       (last),
        .roll_valid (roll_valid),
        .bad_throw  (bad_throw),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       bad;
        logic [2:0] last;
        int         s0;
        int         s1;
        logic       pl;
        logic       go;
        logic       win;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_exp = 0;
    int   n_seen = 0;

    int         m_sc[2];
    logic       m_pl;
    logic       m_go;
    logic       m_win;
    logic [2:0] m_last;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_player"}, int'(player), int'(m_pl));
        chk({tag, "_score0"}, int'(score0), m_sc[0]);
        chk({tag, "_score1"}, int'(score1), m_sc[1]);
        chk({tag, "_last"}, int'(last), int'(m_last));
        chk({tag, "_game_over"}, int'(game_over), int'(m_go));
        chk({tag, "_winner"}, int'(winner), int'(m_win));
    endtask

    task automatic model_reset();
        m_sc[0] = 0;
        m_sc[1] = 0;
        m_pl    = 1'b0;
        m_go    = 1'b0;
        m_win   = 1'b0;
        m_last  = 3'd0;
    endtask

    // Applied at the release edge; pushes the expected strobe outcome.
    task automatic model_release(input int hold, input logic [2:0] thr);
        exp_t e;
        int   idx;
        int   sum;
        if (m_go || hold < MIN_HOLD) return;
        if (thr == 3'd0 || thr == 3'd7) begin
            e.bad = 1'b1;
        end else begin
            e.bad  = 1'b0;
            idx    = m_pl ? 1 : 0;
            sum    = m_sc[idx] + int'(thr);
            m_last = thr;
            if (sum >= TARGET) begin
                m_sc[idx] = TARGET;
                m_go      = 1'b1;
                m_win     = m_pl;
            end else begin
                m_sc[idx] = sum;
                if (thr != 3'd6) m_pl = ~m_pl;
            end
        end
        e.last = m_last;
        e.s0   = m_sc[0];
        e.s1   = m_sc[1];
        e.pl   = m_pl;
        e.go   = m_go;
        e.win  = m_win;
        sb.push_back(e);
        n_exp++;
    endtask

    task automatic roll(input int hold, input logic [2:0] thr);
        button = 1'b1;
        throw  = 3'($urandom_range(1, 6));
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        button = 1'b0;
        throw  = thr;
        @(posedge clk);
        model_release(hold, thr);
        #1;
        @(posedge clk);
        #1;
        chk("strobe_width", int'(roll_valid | bad_throw), 0);
        check_all("post");
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (roll_valid || bad_throw) begin
            n_seen++;
            chk("strobe_excl", int'(roll_valid & bad_throw), 0);
            if (sb.size() == 0) begin
                chk("unexp_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sb_bad_throw", int'(bad_throw), int'(e.bad));
                chk("sb_roll_valid", int'(roll_valid), int'(!e.bad));
                chk("sb_last", int'(last), int'(e.last));
                chk("sb_score0", int'(score0), e.s0);
                chk("sb_score1", int'(score1), e.s1);
                chk("sb_player", int'(player), int'(e.pl));
                chk("sb_game_over", int'(game_over), int'(e.go));
                chk("sb_winner", int'(winner), int'(e.win));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst    = 1'b1;
        button = 1'b1;
        throw  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset_roll_valid", int'(roll_valid), 0);
        chk("reset_bad_throw", int'(bad_throw), 0);

        // Button already high through reset: releasing one cycle later is too short.
        rst = 1'b0;
        @(posedge clk);
        #1;
        button = 1'b0;
        throw  = 3'd5;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_all("post_reset_release");

        roll(3, 3'd4);
        roll(3, 3'd3);
        roll(2, 3'd6);
        roll(1, 3'd2);
        roll(3, 3'd7);
        roll(2, 3'd0);

        roll(2, 3'd1);
        roll(2, 3'd6);
        roll(2, 3'd6);
        roll(2, 3'd6);
        roll(2, 3'd6);
        chk("pre_win_score1", int'(score1), 27);
        roll(3, 3'd5);
        chk("win_game_over", int'(game_over), 1);
        chk("win_clamp", int'(score1), TARGET);
        roll(3, 3'd4);
        roll(2, 3'd7);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_all("reset_after_win");
        roll(2, 3'd2);
        chk("after_reset_score0", int'(score0), 2);

        // Reset in the middle of a hold discards the accumulated hold time.
        button = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        button = 1'b0;
        throw  = 3'd4;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check_all("mid_roll_reset");

        // Reset and a qualified release on the same edge: reset wins.
        button = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        button = 1'b0;
        throw  = 3'd3;
        rst    = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("reset_same_edge");

        for (int i = 0; i < 40; i++) begin
            roll(int'($urandom_range(1, 3)), 3'($urandom_range(0, 7)));
        end

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        chk("strobe_count", n_seen, n_exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
